// File: rtl/fb_pkg.sv
// Shared constants, command opcodes and FSM state encoding for the framebuffer plotter.
// FB_CLEAR_EN adds the CLR state used by the CLEAR command.
package fb_pkg;
  localparam int          FB_W      = 320;
  localparam int          FB_H      = 200;
  localparam int          ROW_BYTES = 40;
  localparam logic [13:0] BUF_BASE1 = 14'd8000;
  localparam logic [12:0] BUF_BYTES = 13'd8000;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_FLIP  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
`ifdef FB_CLEAR_EN
    ST_CLR   = 3'd4,
`endif
    ST_FLIPW = 3'd3
  } state_e;
endpackage

// File: rtl/fb_addr_gen.sv
// Pixel coordinate to bitmap byte address / bit mask, plus bounds check.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic        buf_sel,
  output logic [13:0] addr,
  output logic [7:0]  mask,
  output logic        in_range
);
  logic [13:0] base;
  logic [13:0] y14;

  assign base     = buf_sel ? BUF_BASE1 : 14'd0;
  assign y14      = {6'd0, y};
  // y*40 as y*32 + y*8; worst case 15999 fits in 14 bits
  assign addr     = base + (y14 << 5) + (y14 << 3) + {8'd0, x[8:3]};
  assign mask     = 8'h80 >> x[2:0];
  assign in_range = (x < 9'(FB_W)) && (y < 8'(FB_H));
endmodule

// File: rtl/fb_plotter.sv
// Double-buffered 1bpp draw engine: PLOT (read-modify-write), CLEAR, FLIP-on-vblank.
// Optional feature macro: FB_CLEAR_EN (enables the CLEAR command).
module fb_plotter
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic        cmd_color,
  input  logic        vblank,
  output logic [13:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        display_buf,
  output logic        busy,
  output logic        err
);
  state_e      state;
  logic        vblank_q;
  logic [7:0]  mask_r;
  logic        color_r;
  logic [7:0]  wdata_r;
  logic [7:0]  merged;
  logic [13:0] ag_addr;
  logic [7:0]  ag_mask;
  logic        ag_ok;
`ifdef FB_CLEAR_EN
  logic [12:0] clr_cnt;
`endif

  fb_addr_gen u_addr (
    .x        (cmd_x),
    .y        (cmd_y),
    .buf_sel  (~display_buf),
    .addr     (ag_addr),
    .mask     (ag_mask),
    .in_range (ag_ok)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  // rdata only becomes valid during WR, so the merge is formed combinationally there
  assign merged    = color_r ? (mem_rdata | mask_r) : (mem_rdata & ~mask_r);
  assign mem_wdata = (state == ST_WR) ? merged : wdata_r;

  // Command FSM with registered memory strobes, error pulse and buffer select
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      display_buf <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 14'd0;
      wdata_r     <= 8'd0;
      err         <= 1'b0;
      vblank_q    <= 1'b1;
      mask_r      <= 8'd0;
      color_r     <= 1'b0;
`ifdef FB_CLEAR_EN
      clr_cnt     <= 13'd0;
`endif
    end else begin
      vblank_q <= vblank;
      err      <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_PLOT: if (ag_ok) begin
              mem_addr <= ag_addr;
              mask_r   <= ag_mask;
              color_r  <= cmd_color;
              state    <= ST_RD;
            end else begin
              err <= 1'b1;
            end
            OP_FLIP: state <= ST_FLIPW;
`ifdef FB_CLEAR_EN
            OP_CLEAR: begin
              mem_addr <= display_buf ? 14'd0 : BUF_BASE1;
              mem_we   <= 1'b1;
              wdata_r  <= {8{cmd_color}};
              clr_cnt  <= 13'd0;
              state    <= ST_CLR;
            end
`endif
            default: err <= 1'b1;
          endcase
        end
        ST_RD: begin
          mem_we <= 1'b1;
          state  <= ST_WR;
        end
        ST_WR: begin
          mem_we  <= 1'b0;
          wdata_r <= merged;
          state   <= ST_IDLE;
        end
`ifdef FB_CLEAR_EN
        ST_CLR: begin
          if (clr_cnt == BUF_BYTES - 13'd1) begin
            mem_we <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            clr_cnt  <= clr_cnt + 13'd1;
            mem_addr <= mem_addr + 14'd1;
          end
        end
`endif
        ST_FLIPW: if (vblank && !vblank_q) begin
          display_buf <= ~display_buf;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_plotter.sv
// Directed bench for fb_plotter with a synchronous BRAM model.
module tb_fb_plotter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_color;
  logic        vblank;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        display_buf;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int ff_low   = 0;
  logic [7:0] ram [0:16383];

  fb_plotter dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .vblank(vblank), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .display_buf(display_buf), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // synchronous BRAM plus write counters
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_wdata == 8'hFF && mem_addr < 14'd8000) ff_low <= ff_low + 1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // present one command for exactly one edge; returns just after the acceptance edge
  task automatic issue(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y, input logic c);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int snap;
    int n;
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_x = 9'd0; cmd_y = 8'd0;
    cmd_color = 1'b0; vblank = 1'b0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_disp", display_buf, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_err", err, 0);

    // PLOT (0,0,1) into back buffer 1
    issue(2'd0, 9'd0, 8'd0, 1'b1);
    chk("p0_rd_busy", busy, 1);
    chk("p0_rd_ready", cmd_ready, 0);
    chk("p0_rd_we", mem_we, 0);
    chk("p0_rd_addr", mem_addr, 8000);
    step();
    chk("p0_wr_we", mem_we, 1);
    chk("p0_wr_addr", mem_addr, 8000);
    chk("p0_wr_data", mem_wdata, 8'h80);
    step();
    chk("p0_ready", cmd_ready, 1);
    chk("p0_we_off", mem_we, 0);
    chk("p0_ram", ram[8000], 8'h80);

    // PLOT (319,199,1) then (319,199,0) at the last byte
    issue(2'd0, 9'd319, 8'd199, 1'b1);
    chk("pmax_addr", mem_addr, 15999);
    step();
    chk("pmax_set_data", mem_wdata, 8'h01);
    step();
    issue(2'd0, 9'd319, 8'd199, 1'b0);
    step();
    chk("pmax_clr_we", mem_we, 1);
    chk("pmax_clr_data", mem_wdata, 8'h00);
    step();
    chk("pmax_ram", ram[15999], 8'h00);

    // out-of-range PLOT and reserved op
    snap = wr_cnt;
    issue(2'd0, 9'd320, 8'd5, 1'b1);
    chk("oor_err", err, 1);
    chk("oor_ready", cmd_ready, 1);
    chk("oor_we", mem_we, 0);
    step();
    chk("oor_err_pulse", err, 0);
    issue(2'd0, 9'd5, 8'd200, 1'b1);
    chk("oor_y_err", err, 1);
    issue(2'd3, 9'd0, 8'd0, 1'b1);
    chk("op3_err", err, 1);
    chk("op3_ready", cmd_ready, 1);
    step();
    chk("oor_nowrite", wr_cnt, snap);

    // FLIP with vblank already high waits for the next rising edge
    vblank = 1'b1;
    step(); step();
    issue(2'd2, 9'd0, 8'd0, 1'b0);
    chk("flip_busy", busy, 1);
    step(); step(); step();
    chk("flip_hold_hi", display_buf, 0);
    vblank = 1'b0;
    step(); step();
    chk("flip_hold_lo", display_buf, 0);
    chk("flip_still_busy", busy, 1);
    vblank = 1'b1;
    step();
    chk("flip_toggle", display_buf, 1);
    chk("flip_ready", cmd_ready, 1);

    // draw buffer now 0
    issue(2'd0, 9'd0, 8'd0, 1'b1);
    chk("pf_addr", mem_addr, 0);
    step();
    chk("pf_data", mem_wdata, 8'h80);
    step();

`ifdef FB_CLEAR_EN
    // CLEAR color=1 fills buffer 0 only
    snap = wr_cnt;
    n = ff_low;
    issue(2'd1, 9'd0, 8'd0, 1'b1);
    chk("clr_first_addr", mem_addr, 0);
    chk("clr_first_we", mem_we, 1);
    begin
      int cyc = 0;
      while (!cmd_ready && cyc < 9000) begin step(); cyc++; end
      chk("clr_cycles", cyc, 8000);
    end
    chk("clr_writes", wr_cnt - snap, 8000);
    chk("clr_ff_low", ff_low - n, 8000);
    chk("clr_ram0", ram[0], 8'hFF);
    chk("clr_ram7999", ram[7999], 8'hFF);
    chk("clr_buf1_kept", ram[8000], 8'h80);
    chk("clr_we_off", mem_we, 0);
`else
    snap = wr_cnt;
    issue(2'd1, 9'd0, 8'd0, 1'b1);
    chk("noclr_err", err, 1);
    chk("noclr_ready", cmd_ready, 1);
    step(); step();
    chk("noclr_nowrite", wr_cnt, snap);
`endif

    // reset asserted during WR
    issue(2'd0, 9'd5, 8'd5, 1'b1);
    chk("rwr_addr", mem_addr, 200);
    step();
    chk("rwr_in_wr", mem_we, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rwr_we", mem_we, 0);
    chk("rwr_disp", display_buf, 0);
    chk("rwr_ready", cmd_ready, 1);
    snap = wr_cnt;
    for (int i = 0; i < 5; i++) step();
    chk("rwr_nowrite", wr_cnt, snap);

`ifdef FB_CLEAR_EN
    // reset in the middle of a CLEAR
    issue(2'd1, 9'd0, 8'd0, 1'b0);
    chk("rclr_base", mem_addr, 8000);
    for (int i = 0; i < 50; i++) step();
    chk("rclr_mid_we", mem_we, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rclr_we", mem_we, 0);
    chk("rclr_ready", cmd_ready, 1);
    snap = wr_cnt;
    for (int i = 0; i < 5; i++) step();
    chk("rclr_nowrite", wr_cnt, snap);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
